// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package seg7_pkg;

  // Scan position 0..3, where 0 is the leftmost digit.
  typedef logic [1:0] idx_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low {g,f,e,d,c,b,a} patterns. Entry 0 is the rightmost element.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex to active-low seven-segment decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed common-anode display driver with frame snapshot,
// a blank gap at the start of each slot, and an optional blinking colon.
// The colon is built only when SEG7_COLON_BLINK_EN is defined. Otherwise dp
// is tied off and colon_tick is ignored.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_MAX  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_0,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  input  logic [3:0] digit_3,
  input  logic       colon_tick,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_MAX > 1) ? $clog2(REFRESH_MAX) : 1;

  logic [CW-1:0]   cnt_q, cnt_d;
  idx_t            idx_q, idx_d;
  logic [3:0][3:0] snap_q, snap_d;
  logic            prime_q;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic [6:0]      dec_seg;
  logic            wrap, frame_end, blank;

  assign wrap      = (cnt_q == CW'(REFRESH_MAX - 1));
  assign frame_end = wrap && (idx_q == 2'd3);
  assign blank     = (cnt_q < CW'(BLANK_CYCLES));

  seg7_decode u_dec (
    .hex_i (snap_q[idx_q]),
    .seg_o (dec_seg)
  );

  // Next-state: slot counter, scan index, snapshot at frame end or after reset,
  // and the registered display outputs.
  always_comb begin
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    idx_d  = wrap ? idx_q + 2'd1 : idx_q;
    snap_d = snap_q;
    if (prime_q || frame_end) snap_d = {digit_3, digit_2, digit_1, digit_0};
    an_d   = AN_OFF;
    seg_d  = SEG_BLANK;
    if (!blank) begin
      an_d  = ~(4'b1000 >> idx_q);
      seg_d = dec_seg;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      prime_q <= 1'b1;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      prime_q <= 1'b0;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

`ifdef SEG7_COLON_BLINK_EN
  logic colon_q, colon_d;
  logic dp_q, dp_d;

  // Colon toggles on every tick. It is lit on the dp of the second digit, outside the gap.
  always_comb begin
    colon_d = colon_q ^ colon_tick;
    dp_d    = ~((idx_q == 2'd1) && !blank && colon_q);
  end

  // Colon state and registered dp.
  always_ff @(posedge clk) begin
    if (reset) begin
      colon_q <= 1'b1;
      dp_q    <= 1'b1;
    end else begin
      colon_q <= colon_d;
      dp_q    <= dp_d;
    end
  end

  assign dp = dp_q;
`else
  logic unused_colon_tick;
  assign unused_colon_tick = colon_tick;
  assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (REFRESH_MAX=8, BLANK_CYCLES=2).
// The reference model works from elapsed cycles since reset release. Slot and
// phase come from division. Displayed digits come from the input history at the frame boundary.
module tb_seg7_scan;
  localparam int RM = 8;
  localparam int BC = 2;
  localparam int FR = 4 * RM;
  localparam int HN = 4096;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] d0, d1, d2, d3;
  logic       tick;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seg7_scan #(.REFRESH_MAX(RM), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .reset(reset),
    .digit_0(d0), .digit_1(d1), .digit_2(d2), .digit_3(d3),
    .colon_tick(tick), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] hex;
    logic [6:0] seg;
  } vec_t;

  vec_t        tbl [16];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] hist [HN];
  int          k;
  logic        colon_st;
  int          lit_cnt [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
    end
  endtask

  // One clock with normal operation. dig = {digit_3,digit_2,digit_1,digit_0}.
  task automatic cyc(input logic [15:0] dig, input logic t);
    int c, s, f, src;
    logic [3:0]  ea;
    logic [15:0] h;
    logic [3:0]  nib;
    logic        edp;
    if (k >= HN) begin
      $display("FAIL history_bound: k=%0d limit %0d", k, HN);
      $fatal(1, "history overflow");
    end
    {d3, d2, d1, d0} = dig;
    tick  = t;
    reset = 1'b0;
    hist[k] = dig;
    @(posedge clk); #1;
    c   = k % RM;
    s   = (k / RM) % 4;
    f   = k / FR;
    src = (f == 0) ? 0 : f * FR - 1;
    if (c < BC) begin
      chk("an_blank", an, 4'hF);
      chk("dp_blank", dp, 1);
    end else begin
      ea = 4'b1111;
      ea[3-s] = 1'b0;
      h   = hist[src];
      nib = h[4*s +: 4];
      chk("an_lit", an, ea);
      chk("seg_lit", seg, tbl[nib].seg);
`ifdef SEG7_COLON_BLINK_EN
      edp = !(s == 1 && colon_st);
`else
      edp = 1'b1;
`endif
      chk("dp_lit", dp, edp);
      lit_cnt[s]++;
    end
    colon_st = colon_st ^ t;
    k++;
  endtask

  task automatic rst_cyc(input logic t);
    reset = 1'b1;
    tick  = t;
    @(posedge clk); #1;
    chk("an_rst", an, 4'hF);
    chk("seg_rst", seg, 7'h7F);
    chk("dp_rst", dp, 1);
    k = 0;
    colon_st = 1'b1;
  endtask

  task automatic clr_lit();
    for (int i = 0; i < 4; i++) lit_cnt[i] = 0;
  endtask

  task automatic chk_lit(input string name);
    for (int i = 0; i < 4; i++) chk(name, lit_cnt[i], RM - BC);
  endtask

  initial begin
    logic [15:0] cur;
    int n;
    tbl[0]  = '{4'h0, 7'h40}; tbl[1]  = '{4'h1, 7'h79};
    tbl[2]  = '{4'h2, 7'h24}; tbl[3]  = '{4'h3, 7'h30};
    tbl[4]  = '{4'h4, 7'h19}; tbl[5]  = '{4'h5, 7'h12};
    tbl[6]  = '{4'h6, 7'h02}; tbl[7]  = '{4'h7, 7'h78};
    tbl[8]  = '{4'h8, 7'h00}; tbl[9]  = '{4'h9, 7'h10};
    tbl[10] = '{4'hA, 7'h08}; tbl[11] = '{4'hB, 7'h03};
    tbl[12] = '{4'hC, 7'h46}; tbl[13] = '{4'hD, 7'h21};
    tbl[14] = '{4'hE, 7'h06}; tbl[15] = '{4'hF, 7'h0E};
    {d3, d2, d1, d0} = 16'h0;
    tick = 1'b0;
    reset = 1'b1;
    k = 0;
    colon_st = 1'b1;

    // Reset held for 5 cycles.
    for (int i = 0; i < 5; i++) rst_cyc(1'b0);

    // Scan order: frame 0 shows 1,2,3,4.
    clr_lit();
    for (int i = 0; i < FR; i++) cyc(16'h4321, 1'b0);
    chk_lit("lit_cnt_f0");

    // No tearing: change to 9999 inside the idx=1 slot of frame 1.
    for (int i = 0; i < 10; i++) cyc(16'h4321, 1'b0);
    for (int i = 0; i < 2 * FR - 10; i++) cyc(16'h9999, 1'b0);

    // Hex decode: each table value on digit_3 for one frame.
    for (int v = 0; v < 16; v++) begin
      clr_lit();
      for (int i = 0; i < FR; i++) cyc({tbl[v].hex, 12'h765}, 1'b0);
      if (v == 15) chk_lit("lit_cnt_hex");
    end

    // Colon: one tick mid-frame, a second one frame later.
    for (int i = 0; i < 5; i++) cyc(16'h1234, 1'b0);
    cyc(16'h1234, 1'b1);
    for (int i = 0; i < FR; i++) cyc(16'h1234, 1'b0);
    cyc(16'h1234, 1'b1);
    for (int i = 0; i < FR; i++) cyc(16'h1234, 1'b0);
    // Tick on the frame-boundary edge.
    while ((k % FR) != FR - 1) cyc(16'h1234, 1'b0);
    cyc(16'h5678, 1'b1);
    for (int i = 0; i < FR; i++) cyc(16'h5678, 1'b0);
    // Tick held high for several cycles.
    for (int i = 0; i < 13; i++) cyc(16'h5678, 1'b1);
    for (int i = 0; i < FR; i++) cyc(16'h5678, 1'b0);

    // Randomized digits and ticks.
    cur = 16'($urandom);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) cur = 16'($urandom);
      cyc(cur, $urandom_range(15) == 0);
    end

    // Reset mid-frame during the idx=2 slot.
    n = 0;
    while (!(((k / RM) % 4) == 2 && (k % RM) == 4) && n < 2 * FR) begin
      cyc(cur, 1'b0);
      n++;
    end
    chk("reach_idx2", ((k / RM) % 4), 2);
    rst_cyc(1'b1);
    clr_lit();
    for (int i = 0; i < FR; i++) cyc(16'h8765, 1'b0);
    chk_lit("lit_cnt_rst");
    for (int i = 0; i < FR; i++) cyc(16'hCAFE, $urandom_range(3) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
